// File: rtl/audio_stereo_in_if.sv
// Consumer-side bus of the stereo PWM receiver: head sample pair, handshake and status flags.
interface audio_stereo_in_if;
  logic [15:0] stereo_pcm;
  logic        stereo_pcm_rdy;
  logic        stereo_pcm_ack;
  logic        fifo_full;
  logic        overrun;

  modport master (
    output stereo_pcm,
    output stereo_pcm_rdy,
    output fifo_full,
    output overrun,
    input  stereo_pcm_ack
  );

  modport slave (
    input  stereo_pcm,
    input  stereo_pcm_rdy,
    input  fifo_full,
    input  overrun,
    output stereo_pcm_ack
  );
endinterface

// File: rtl/audio_stereo_in.sv
// Stereo 1-bit PWM receiver: per-frame high-cycle counting per channel, {left,right} pairs
// queued in a small FIFO drained through a valid/ack handshake.
module audio_stereo_in #(
  parameter int unsigned FRAME_LEN  = 255,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic               clk_audio,
  input  logic               aclr,
  input  logic               left_in,
  input  logic               right_in,
  audio_stereo_in_if.master  pcm
);
  localparam int unsigned CW   = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam int unsigned AW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNTW = AW + 1;

  logic          l_q1, l_s, r_q1, r_s;
  logic [CW-1:0] frame_cnt;
  logic [7:0]    acc_l, acc_r;
  logic [7:0]    sample_l, sample_r;
  logic          frame_end;

  logic [15:0]     mem [FIFO_DEPTH];
  logic [AW-1:0]   rd_ptr, wr_ptr;
  logic [CNTW-1:0] count;
  logic            rdy, full, pop, push_ok;

  assign frame_end = (frame_cnt == CW'(FRAME_LEN - 1));
  assign sample_l  = acc_l + 8'(l_s);
  assign sample_r  = acc_r + 8'(r_s);

  assign rdy  = (count != '0);
  assign full = (count == CNTW'(FIFO_DEPTH));
  assign pop  = pcm.stereo_pcm_ack && rdy;
  // A pop on the same edge frees the slot, so a full FIFO can still take the frame-end pair.
  assign push_ok = frame_end && (!full || pop);

  always_ff @(posedge clk_audio) begin
    if (aclr) begin
      l_q1      <= 1'b0;
      l_s       <= 1'b0;
      r_q1      <= 1'b0;
      r_s       <= 1'b0;
      frame_cnt <= '0;
      acc_l     <= '0;
      acc_r     <= '0;
    end else begin
      l_q1 <= left_in;
      l_s  <= l_q1;
      r_q1 <= right_in;
      r_s  <= r_q1;
      if (frame_end) begin
        frame_cnt <= '0;
        acc_l     <= '0;
        acc_r     <= '0;
      end else begin
        frame_cnt <= frame_cnt + 1'b1;
        acc_l     <= sample_l;
        acc_r     <= sample_r;
      end
    end
  end

  always_ff @(posedge clk_audio) begin
    if (aclr) begin
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      count         <= '0;
      pcm.overrun   <= 1'b0;
    end else begin
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      if (push_ok)
        wr_ptr <= wr_ptr + 1'b1;
      if (push_ok && !pop)
        count <= count + 1'b1;
      else if (pop && !push_ok)
        count <= count - 1'b1;
      if (frame_end && !push_ok)
        pcm.overrun <= 1'b1;
    end
  end

  always_ff @(posedge clk_audio) begin
    if (!aclr && push_ok)
      mem[wr_ptr] <= {sample_l, sample_r};
  end

  always_comb begin
    pcm.stereo_pcm     = rdy ? mem[rd_ptr] : '0;
    pcm.stereo_pcm_rdy = rdy;
    pcm.fifo_full      = full;
  end
endmodule

// File: tb/tb_audio_stereo_in.sv
// Bench for audio_stereo_in: input-history scoreboard of frame sums and FIFO contents.
module tb_audio_stereo_in;
  localparam int unsigned FL    = 255;
  localparam int unsigned DEPTH = 4;

  logic clk_audio = 1'b0;
  logic aclr      = 1'b1;
  logic left_in   = 1'b0;
  logic right_in  = 1'b0;

  audio_stereo_in_if bus ();

  audio_stereo_in #(.FRAME_LEN(FL), .FIFO_DEPTH(DEPTH)) dut (
    .clk_audio (clk_audio),
    .aclr      (aclr),
    .left_in   (left_in),
    .right_in  (right_in),
    .pcm       (bus.master)
  );

  always #5 clk_audio = ~clk_audio;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  // Model state: input history since reset release, expected FIFO, sticky overrun.
  int unsigned cyc;
  bit          hl[$];
  bit          hr[$];
  logic [15:0] mq[$];
  bit          movr;

  function automatic logic [1:0] gen(input int mode, input int unsigned c);
    int unsigned pos, f;
    logic [1:0] v;
    pos = (c + 2) % FL;
    f   = (c + 2) / FL;
    v   = 2'b00;
    case (mode)
      1: v = 2'b11;
      2: begin
        if (f == 1) v = {(pos < 127), 1'b0};
        else if (f == 2) v = 2'b01;
      end
      3: v = {(pos < 20 * f + 3), (int'(pos) >= 250 - 30 * int'(f))};
      4: v = 2'($urandom_range(0, 3));
      5: v = 2'b10;
      default: v = 2'b00;
    endcase
    return v;
  endfunction

  task automatic model_clear();
    cyc  = 0;
    movr = 1'b0;
    hl.delete();
    hr.delete();
    mq.delete();
  endtask

  // One clock of stimulus; the model computes a frame sum from the input cycles feeding it.
  task automatic step(input bit l, input bit r, input bit ack);
    bit pop, push, full;
    int sl, sr, lo;
    left_in  = l;
    right_in = r;
    bus.stereo_pcm_ack = ack;
    pop  = ack && (mq.size() != 0);
    push = (cyc % FL) == FL - 1;
    full = (mq.size() == DEPTH);
    sl = 0;
    sr = 0;
    if (push) begin
      lo = (cyc >= 256) ? int'(cyc) - 256 : 0;
      for (int i = lo; i <= int'(cyc) - 2; i++) begin
        sl += int'(hl[i]);
        sr += int'(hr[i]);
      end
    end
    hl.push_back(l);
    hr.push_back(r);
    if (pop) void'(mq.pop_front());
    if (push) begin
      if (!full || pop) mq.push_back({8'(sl), 8'(sr)});
      else movr = 1'b1;
    end
    @(posedge clk_audio);
    #1;
    bus.stereo_pcm_ack = 1'b0;
    cyc++;
  endtask

  task automatic run(input int unsigned n, input int mode, input bit autoack);
    logic [1:0]  lr;
    bit          a;
    logic [18:0] exp_v, got_v;
    for (int unsigned k = 0; k < n; k++) begin
      lr = gen(mode, cyc);
      a  = autoack && (mq.size() != 0);
      if (a) begin
        n_cmp++;
        if (bus.stereo_pcm !== mq[0]) begin
          n_bad++;
          $display("FAIL pop_data cyc=%0d got=%h exp=%h", cyc, bus.stereo_pcm, mq[0]);
        end
      end
      step(lr[1], lr[0], a);
      exp_v = {(mq.size() != 0), (mq.size() == DEPTH), movr,
               (mq.size() != 0) ? mq[0] : 16'h0000};
      got_v = {bus.stereo_pcm_rdy, bus.fifo_full, bus.overrun, bus.stereo_pcm};
      n_cmp++;
      if (got_v !== exp_v) begin
        n_bad++;
        $display("FAIL cycle_state cyc=%0d got{rdy,full,ovr,pcm}=%h exp=%h", cyc, got_v, exp_v);
      end
    end
  endtask

  task automatic do_reset(input int unsigned n);
    aclr = 1'b1;
    bus.stereo_pcm_ack = 1'b0;
    repeat (n) @(posedge clk_audio);
    #1;
    model_clear();
    aclr = 1'b0;
  endtask

  task automatic test_reset();
    aclr = 1'b1;
    left_in = 1'b1;
    right_in = 1'b1;
    repeat (3) @(posedge clk_audio);
    #1;
    n_cmp++;
    if ({bus.stereo_pcm, bus.stereo_pcm_rdy, bus.fifo_full, bus.overrun} !== 19'h0) begin
      n_bad++;
      $display("FAIL reset_held got pcm=%h rdy=%b full=%b ovr=%b exp all 0",
               bus.stereo_pcm, bus.stereo_pcm_rdy, bus.fifo_full, bus.overrun);
    end
    model_clear();
    aclr = 1'b0;
    n_cmp++;
    if ({bus.stereo_pcm, bus.stereo_pcm_rdy, bus.fifo_full, bus.overrun} !== 19'h0) begin
      n_bad++;
      $display("FAIL reset_release got pcm=%h rdy=%b full=%b ovr=%b exp all 0",
               bus.stereo_pcm, bus.stereo_pcm_rdy, bus.fifo_full, bus.overrun);
    end
    run(FL - 1, 5, 1'b0);
    n_cmp++;
    if (bus.stereo_pcm_rdy !== 1'b0) begin
      n_bad++;
      $display("FAIL rdy_before_first got=%b exp=0", bus.stereo_pcm_rdy);
    end
    run(1, 5, 1'b0);
    n_cmp++;
    if (bus.stereo_pcm_rdy !== 1'b1 || bus.stereo_pcm !== 16'hFD00) begin
      n_bad++;
      $display("FAIL first_word got rdy=%b pcm=%h exp rdy=1 pcm=fd00",
               bus.stereo_pcm_rdy, bus.stereo_pcm);
    end
    run(3, 5, 1'b1);
  endtask

  task automatic test_duty();
    do_reset(2);
    run(FL, 2, 1'b0);
    run(FL, 2, 1'b1);
    n_cmp++;
    if (bus.stereo_pcm !== 16'h7F00) begin
      n_bad++;
      $display("FAIL duty_left got=%h exp=7f00", bus.stereo_pcm);
    end
    run(FL, 2, 1'b1);
    n_cmp++;
    if (bus.stereo_pcm !== 16'h00FF) begin
      n_bad++;
      $display("FAIL duty_right got=%h exp=00ff", bus.stereo_pcm);
    end
    run(3, 2, 1'b1);
  endtask

  task automatic test_extremes();
    do_reset(2);
    run(FL * 4, 1, 1'b1);
    n_cmp++;
    if (bus.stereo_pcm !== 16'hFFFF) begin
      n_bad++;
      $display("FAIL all_high got=%h exp=ffff", bus.stereo_pcm);
    end
    run(FL * 3, 0, 1'b1);
    n_cmp++;
    if (bus.stereo_pcm_rdy !== 1'b1 || bus.stereo_pcm !== 16'h0000) begin
      n_bad++;
      $display("FAIL all_low got rdy=%b pcm=%h exp rdy=1 pcm=0000",
               bus.stereo_pcm_rdy, bus.stereo_pcm);
    end
    run(3, 0, 1'b1);
  endtask

  task automatic test_fill_overrun();
    do_reset(2);
    run(FL * 4, 3, 1'b0);
    n_cmp++;
    if (bus.fifo_full !== 1'b1 || bus.overrun !== 1'b0) begin
      n_bad++;
      $display("FAIL fill4 got full=%b ovr=%b exp full=1 ovr=0", bus.fifo_full, bus.overrun);
    end
    run(FL, 3, 1'b0);
    n_cmp++;
    if (bus.overrun !== 1'b1) begin
      n_bad++;
      $display("FAIL overrun5 got=%b exp=1", bus.overrun);
    end
    run(DEPTH + 2, 3, 1'b1);
    n_cmp++;
    if (bus.stereo_pcm_rdy !== 1'b0) begin
      n_bad++;
      $display("FAIL drained got rdy=%b exp=0", bus.stereo_pcm_rdy);
    end
    run(FL, 3, 1'b1);
    n_cmp++;
    if (bus.overrun !== 1'b1) begin
      n_bad++;
      $display("FAIL overrun_sticky got=%b exp=1", bus.overrun);
    end
    do_reset(2);
    n_cmp++;
    if (bus.overrun !== 1'b0) begin
      n_bad++;
      $display("FAIL overrun_clear got=%b exp=0", bus.overrun);
    end
  endtask

  task automatic test_collision();
    logic [15:0] tail;
    do_reset(2);
    run(FL * 4, 4, 1'b0);
    run(FL - 1, 4, 1'b0);
    n_cmp++;
    if (bus.stereo_pcm !== mq[0]) begin
      n_bad++;
      $display("FAIL coll_head got=%h exp=%h", bus.stereo_pcm, mq[0]);
    end
    step(1'b1, 1'b0, 1'b1);
    tail = mq[DEPTH - 1];
    n_cmp++;
    if (bus.fifo_full !== 1'b1 || bus.overrun !== 1'b0 || mq.size() != DEPTH) begin
      n_bad++;
      $display("FAIL collision got full=%b ovr=%b exp full=1 ovr=0",
               bus.fifo_full, bus.overrun);
    end
    run(DEPTH - 1, 4, 1'b1);
    n_cmp++;
    if (bus.stereo_pcm !== tail) begin
      n_bad++;
      $display("FAIL coll_tail got=%h exp=%h", bus.stereo_pcm, tail);
    end
    run(2, 4, 1'b1);
  endtask

  task automatic test_reset_midframe();
    do_reset(2);
    run(FL + 100, 1, 1'b0);
    do_reset(1);
    n_cmp++;
    if (bus.stereo_pcm_rdy !== 1'b0 || bus.stereo_pcm !== 16'h0000) begin
      n_bad++;
      $display("FAIL mid_reset_empty got rdy=%b pcm=%h exp rdy=0 pcm=0000",
               bus.stereo_pcm_rdy, bus.stereo_pcm);
    end
    run(FL - 1, 1, 1'b0);
    run(1, 1, 1'b0);
    n_cmp++;
    if (bus.stereo_pcm_rdy !== 1'b1 || bus.stereo_pcm !== 16'hFDFD) begin
      n_bad++;
      $display("FAIL mid_reset_word got rdy=%b pcm=%h exp rdy=1 pcm=fdfd",
               bus.stereo_pcm_rdy, bus.stereo_pcm);
    end
  endtask

  initial begin
    bus.stereo_pcm_ack = 1'b0;
    model_clear();
    test_reset();
    test_duty();
    test_extremes();
    test_fill_overrun();
    test_collision();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/audio_stereo_in.md
# audio_stereo_in

Stereo 1-bit audio receiver: the counterpart of the stereo PWM output path. It takes two 1-bit PWM streams (left, right), one per channel, each carrying one 8-bit sample per 255-cycle frame. It recovers each sample by counting high cycles over the frame and queues the resulting `{left, right}` 16-bit words in a small FIFO. The consumer drains the FIFO with a valid/ack handshake.

## Interface

Parameters:

- `FRAME_LEN`, 255: cycles per PWM frame. The high-cycle count spans 0..FRAME_LEN and must fit in 8 bits.
- `FIFO_DEPTH`, 4: number of sample-pair entries; power of 2, minimum 2.

Ports:

- `clk_audio` in 1: single clock for the whole block.
- `aclr` in 1: reset, synchronous and active-high.
- `left_in` in 1: left PWM input, asynchronous to the frame.
- `right_in` in 1: right PWM input, asynchronous to the frame.
- `stereo_pcm` out 16: head FIFO entry; `[15:8]` is left, `[7:0]` is right. Reads 16'h0000 when the FIFO is empty.
- `stereo_pcm_rdy` out 1: FIFO non-empty.
- `stereo_pcm_ack` in 1: pops the head entry. Ignored when `stereo_pcm_rdy` is 0.
- `fifo_full` out 1: FIFO holds FIFO_DEPTH entries.
- `overrun` out 1: sticky flag. Set when a completed sample pair is dropped; cleared only by `aclr`.

## Operation

- Each input passes through a 2-flop synchronizer. The synchronized bits are `l_s` and `r_s`.
- Frame counter `frame_cnt` counts 0..FRAME_LEN-1 and wraps to 0.
- Per-channel 8-bit accumulators `acc_l` and `acc_r`:
  - When `frame_cnt` < FRAME_LEN-1: `acc` <= `acc` + bit.
  - When `frame_cnt` == FRAME_LEN-1 (frame end): sample = `acc` + bit, then `acc` <= 0.
- The accumulator never exceeds FRAME_LEN, so no saturation logic is needed. An all-high frame yields 255 and an all-low frame yields 0.
- At frame end, `{sample_l, sample_r}` is pushed into the FIFO on the same clock edge.
- FIFO:
  - Circular buffer with `rd_ptr`, `wr_ptr` and `count` (width log2(FIFO_DEPTH)+1).
  - `stereo_pcm_rdy` = (`count` != 0).
  - `fifo_full` = (`count` == FIFO_DEPTH).
  - `stereo_pcm` = `mem[rd_ptr]` when non-empty, otherwise 0.
- Pop: on a clock edge with `stereo_pcm_ack` && `stereo_pcm_rdy`, `rd_ptr` advances.
- Push when full:
  - If a pop happens in the same cycle, the push is accepted and `count` is unchanged.
  - Otherwise the pair is dropped and `overrun` <= 1. Stored entries are untouched.
- Pointers wrap modulo FIFO_DEPTH.
- Reset clears `frame_cnt`, both accumulators, both synchronizers, both pointers, `count` and `overrun`. A reset mid-frame discards the partial frame, and the first frame after reset starts at `frame_cnt` = 0.

## Timing

Output values while `aclr` is high and on the first cycle after release:

- `stereo_pcm` = 0
- `stereo_pcm_rdy` = 0
- `fifo_full` = 0
- `overrun` = 0

Latency and ordering:

- Input-to-accumulator latency is 2 cycles (synchronizer). The frame boundary is defined on the synchronized stream.
- The first frame completes on the edge at the FRAME_LEN-th cycle after reset release. `stereo_pcm_rdy` rises on that edge and is visible in the following cycle.
- `stereo_pcm` is stable whenever `stereo_pcm_rdy` is 1 and changes only after an accepted pop or a push into an empty FIFO.
- Ack is combinationally qualified by rdy; there is no combinational path from `stereo_pcm_ack` to any output.
- A push and a pop in the same cycle with count 0 cannot occur, because a pop requires rdy.
- `overrun` rises on the edge of the dropped push and stays high until reset.
- Sustained throughput is one pair per FRAME_LEN cycles. The consumer must ack within FIFO_DEPTH·FRAME_LEN cycles to avoid overrun.

## Test plan

- **Reset values:** assert `aclr` for 3 cycles, release.
  - -> All outputs 0.
  - -> `stereo_pcm_rdy` stays 0 for FRAME_LEN-1 cycles.
  - -> First word appears after FRAME_LEN cycles.
- **Duty decode:** drive left high 127 of 255 cycles and right constant 0, frame-aligned after the 2-cycle sync delay. Then drive left 0 and right all-high.
  - -> Words 16'h7F00, then 16'h00FF.
- **Extremes and stream:**
  - -> Both inputs constant 1 yields 16'hFFFF on every frame.
  - -> Both inputs constant 0 yields 16'h0000 with `stereo_pcm_rdy` = 1.
- **Fill and overrun:** never ack for 5 frames.
  - -> `fifo_full` = 1 after frame 4 and `overrun` = 1 after frame 5.
  - -> Draining yields frames 1–4 in order.
  - -> `overrun` stays 1 until `aclr`.
- **Push/pop collision at full:** with the FIFO full, ack on exactly the frame-end cycle.
  - -> `count` stays 4, `overrun` stays 0.
  - -> The new pair becomes the tail entry.
- **Reset mid-frame:** pulse `aclr` at `frame_cnt` = 100 with inputs high.
  - -> FIFO is emptied.
  - -> The next word appears FRAME_LEN cycles after release and equals the full-frame count, not a partial sum.
